// File: rtl/sram_like_responder.sv
// SRAM-like bus slave: accepts req/addr_ok requests into an internal word array
// and returns in-order data_ok responses after a fixed minimum latency.
module sram_like_responder #(
   parameter int unsigned MEM_AW = 12,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned LAT    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        addr_hold,
   input  logic        data_hold,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_BUSY,
      S_FULL
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    count_q, count_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          q_wr_q   [DEPTH];
   logic          q_wr_d   [DEPTH];
   logic [31:0]   q_data_q [DEPTH];
   logic [31:0]   q_data_d [DEPTH];
   logic [3:0]    q_cnt_q  [DEPTH];
   logic [3:0]    q_cnt_d  [DEPTH];

   logic [31:0]       mem_q [2**MEM_AW];
   logic [MEM_AW-1:0] word_idx;
   logic [31:0]       mem_rd;
   logic              head_ready;
   logic              push;
   logic              pop;
   logic              unused_in;

   always_comb begin
      word_idx   = addr[MEM_AW+1:2];
      mem_rd     = mem_q[word_idx];
      head_ready = (q_cnt_q[rptr_q] == '0);
      push       = req & addr_ok;
      pop        = data_ok;
      unused_in  = ^{size, addr[31:MEM_AW+2], addr[1:0]};
   end

   // Writes land at the accept edge, so a read accepted next cycle already sees them.
   always_ff @(posedge clk) begin
      if (push && wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         q_wr_d[i]   = q_wr_q[i];
         q_data_d[i] = q_data_q[i];
         q_cnt_d[i]  = (q_cnt_q[i] != '0) ? q_cnt_q[i] - 4'd1 : '0;
      end
      if (push) begin
         q_wr_d[wptr_q]   = wr;
         q_data_d[wptr_q] = wr ? '0 : mem_rd;
         q_cnt_d[wptr_q]  = 4'(LAT - 1);
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_wr_q[i]   <= 1'b0;
            q_data_q[i] <= '0;
            q_cnt_q[i]  <= '0;
         end
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_wr_q[i]   <= q_wr_d[i];
            q_data_q[i] <= q_data_d[i];
            q_cnt_q[i]  <= q_cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_EMPTY;
      else         state_q <= state_d;
   end

   // State mirrors occupancy; a simultaneous push and pop holds it.
   always_comb begin
      state_d = state_q;
      if (push && !pop) begin
         state_d = (count_q == 4'(DEPTH - 1)) ? S_FULL : S_BUSY;
      end else if (pop && !push) begin
         state_d = (count_q == 4'd1) ? S_EMPTY : S_BUSY;
      end
   end

   always_comb begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      case (state_q)
         S_EMPTY: addr_ok = ~addr_hold;
         S_BUSY: begin
            addr_ok = ~addr_hold;
            data_ok = head_ready & ~data_hold;
         end
         S_FULL:  data_ok = head_ready & ~data_hold;
         default: begin
            addr_ok = 1'b0;
            data_ok = 1'b0;
         end
      endcase
   end

   always_comb begin
      rdata = '0;
      if (data_ok && !q_wr_q[rptr_q]) rdata = q_data_q[rptr_q];
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized self-checking bench for sram_like_responder against a
// time-stamped response-queue reference model.
module tb_sram_like_responder;

   localparam int unsigned MEM_AW = 12;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LAT    = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req, wr, addr_hold, data_hold;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;

   sram_like_responder #(
      .MEM_AW (MEM_AW),
      .DEPTH  (DEPTH),
      .LAT    (LAT)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .wstrb     (wstrb),
      .addr      (addr),
      .wdata     (wdata),
      .addr_hold (addr_hold),
      .data_hold (data_hold),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          ready;
   } resp_t;

   resp_t       mq[$];
   logic [31:0] mem_m [2**MEM_AW];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   logic        last_acc;
   logic [31:0] last_resp;
   int          resp_cnt;
   int          stall_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model.
   task automatic step();
      logic        exp_aok, exp_dok;
      logic [31:0] exp_rd;
      resp_t       e;
      int          idx;
      @(negedge clk);
      if (!resetn) mq.delete();
      exp_aok = !addr_hold && (mq.size() < DEPTH);
      exp_dok = (mq.size() != 0) && (cyc >= mq[0].ready) && !data_hold;
      exp_rd  = exp_dok ? mq[0].data : 32'h0;
      check("addr_ok", {31'b0, addr_ok}, {31'b0, exp_aok});
      check("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
      check("rdata", rdata, exp_rd);
      if (data_ok) begin
         last_resp = rdata;
         resp_cnt++;
      end
      if (req && !addr_ok) stall_cnt++;
      last_acc = req && exp_aok && resetn;
      if (resetn) begin
         if (exp_dok) void'(mq.pop_front());
         if (last_acc) begin
            idx = int'(addr[MEM_AW+1:2]);
            if (wr) begin
               e.data = 32'h0;
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
               e.data = mem_m[idx];
            end
            e.ready = cyc + int'(LAT);
            mq.push_back(e);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      int n;
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
      n = 0;
      last_acc = 1'b0;
      while (!last_acc && n < 40) begin
         step();
         n++;
      end
      check("req_accepted", {31'b0, last_acc}, 32'd1);
      req = 1'b0;
   endtask

   task automatic drain();
      int n;
      req = 1'b0; addr_hold = 1'b0; data_hold = 1'b0;
      n = 0;
      while (mq.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_empty", mq.size(), 32'd0);
      step();
   endtask

   initial begin
      for (int i = 0; i < 2**MEM_AW; i++) mem_m[i] = 32'h0;
      resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
      addr = '0; wdata = '0; addr_hold = 1'b0; data_hold = 1'b0;
      last_resp = '0; resp_cnt = 0; stall_cnt = 0;

      step();
      step();
      resetn = 1'b1;
      step();

      // Preload words 0..31 so every address the bench reads has defined contents.
      for (int i = 0; i < 32; i++)
         do_req(1'b1, 32'(i * 4), (i == 16) ? 32'hDEADBEEF : $urandom, 4'hF);
      drain();

      do_req(1'b0, 32'h40, 32'h0, 4'h0);
      drain();
      check("single_read", last_resp, 32'hDEADBEEF);

      do_req(1'b1, 32'h40, 32'h11223344, 4'b0101);
      do_req(1'b0, 32'h40, 32'h0, 4'h0);
      drain();
      check("wr_rd_merge", last_resp, 32'hDE22BE44);

      data_hold = 1'b1;
      for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0);
      req = 1'b1; wr = 1'b0; addr = 32'h10;
      for (int i = 0; i < 3; i++) step();
      data_hold = 1'b0;
      do_req(1'b0, 32'h10, 32'h0, 4'h0);
      drain();

      stall_cnt = 0;
      resp_cnt = 0;
      for (int i = 0; i < 16; i++) do_req(1'b0, 32'((i % 32) * 4), 32'h0, 4'h0);
      drain();
      check("stream_stalls", stall_cnt, 32'd0);
      check("stream_resps", resp_cnt, 32'd16);

      req = 1'b1; wr = 1'b0; addr = 32'h8; addr_hold = 1'b1;
      for (int i = 0; i < 3; i++) step();
      addr_hold = 1'b0;
      do_req(1'b0, 32'h8, 32'h0, 4'h0);
      drain();

      data_hold = 1'b1;
      do_req(1'b1, 32'h14, 32'hCAFE0005, 4'hF);
      for (int i = 0; i < 3; i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0);
      resetn = 1'b0;
      step();
      step();
      data_hold = 1'b0;
      resetn = 1'b1;
      resp_cnt = 0;
      for (int i = 0; i < 3; i++) step();
      do_req(1'b0, 32'h14, 32'h0, 4'h0);
      drain();
      check("reset_resps", resp_cnt, 32'd1);
      check("reset_persist", last_resp, 32'hCAFE0005);

      for (int i = 0; i < 400; i++) begin
         req       = ($urandom_range(0, 9) < 7);
         wr        = $urandom_range(0, 2) == 0;
         addr      = 32'($urandom_range(0, 31) * 4);
         wdata     = $urandom;
         wstrb     = 4'($urandom_range(0, 15));
         size      = 2'($urandom_range(0, 2));
         addr_hold = ($urandom_range(0, 9) < 2);
         data_hold = ($urandom_range(0, 9) < 3);
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
